// File: rtl/pwm_sample_sequencer.sv
// Paces buffered 16-bit audio samples into the PWM reducer once per sample tick
// and loads the reducer's answer into the PWM level register.
module pwm_sample_sequencer #(
    parameter int CLK_DIV    = 3125,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [15:0]                   red_in,
    output logic                          red_start,
    input  logic [15:0]                   red_out,
    input  logic                          red_rdy,
    output logic [15:0]                   pwm_level,
    output logic                          pwm_load,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          underrun,
    output logic                          late,
    output logic                          timeout_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_LOAD  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [15:0]     tick_cnt_r;
    logic            tick_s;
    logic [15:0]     mem_r [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [WW-1:0]   wait_cnt_r;
    logic            empty_s;
    logic            full_s;
    logic            push_s;
    logic            pop_s;
    logic            underrun_s;
    logic            late_s;
    logic            timeout_s;
    logic            latch_s;
    logic            inc_wait_s;

    assign tick_s     = (tick_cnt_r == 16'(CLK_DIV - 1));
    assign empty_s    = (count_r == {CW{1'b0}});
    assign full_s     = (count_r == CW'(FIFO_DEPTH));
    assign push_s     = in_valid & ~full_s;
    assign in_ready   = ~full_s;
    assign fifo_count = count_r;

    // Free-running sample-rate divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= 16'd0;
        end else if (tick_s) begin
            tick_cnt_r <= 16'd0;
        end else begin
            tick_cnt_r <= tick_cnt_r + 16'd1;
        end
    end

    // Sample storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Next-state and per-cycle event decode. Pop only sees registered occupancy,
    // so a sample pushed into an empty FIFO waits for the following tick.
    always_comb begin
        state_s    = state_r;
        pop_s      = 1'b0;
        underrun_s = 1'b0;
        late_s     = 1'b0;
        timeout_s  = 1'b0;
        latch_s    = 1'b0;
        inc_wait_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (tick_s && !empty_s) begin
                    pop_s   = 1'b1;
                    state_s = S_ISSUE;
                end else if (tick_s) begin
                    underrun_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                late_s  = tick_s;
                state_s = S_WAIT;
            end
            S_WAIT: begin
                late_s = tick_s;
                if (red_rdy) begin
                    latch_s = 1'b1;
                    state_s = S_LOAD;
                end else if (wait_cnt_r == WW'(TIMEOUT - 1)) begin
                    timeout_s = 1'b1;
                    state_s   = S_IDLE;
                end else begin
                    inc_wait_s = 1'b1;
                end
            end
            S_LOAD: begin
                late_s  = tick_s;
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Control state, FIFO pointers and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            wait_cnt_r  <= {WW{1'b0}};
            red_in      <= 16'd0;
            red_start   <= 1'b0;
            pwm_level   <= 16'd0;
            pwm_load    <= 1'b0;
            underrun    <= 1'b0;
            late        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_r <= state_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
                red_in   <= mem_r[rd_ptr_r];
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (state_r == S_ISSUE) begin
                wait_cnt_r <= {WW{1'b0}};
            end else if (inc_wait_s) begin
                wait_cnt_r <= wait_cnt_r + WW'(1);
            end
            red_start <= (state_s == S_ISSUE);
            pwm_load  <= latch_s;
            if (latch_s) begin
                pwm_level <= red_out;
            end
            underrun    <= underrun_s;
            late        <= late_s;
            timeout_err <= timeout_s;
        end
    end

endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// Bench for pwm_sample_sequencer: a timeline reference model (queue + transaction
// window) predicts every output each cycle; a reducer model answers red_start.
module tb_pwm_sample_sequencer;

    localparam logic [41:0] RESET_VEC = {1'b1, 4'd0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] red_in;
    logic        red_start;
    logic [15:0] red_out;
    logic        red_rdy;
    logic [15:0] pwm_level;
    logic        pwm_load;
    logic [3:0]  fifo_count;
    logic        underrun;
    logic        late;
    logic        timeout_err;

    int n_chk = 0;
    int n_fail = 0;
    int red_delay = 2;
    bit stall = 1'b0;

    pwm_sample_sequencer #(.CLK_DIV(16), .FIFO_DEPTH(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .red_in(red_in), .red_start(red_start), .red_out(red_out), .red_rdy(red_rdy),
        .pwm_level(pwm_level), .pwm_load(pwm_load), .fifo_count(fifo_count),
        .underrun(underrun), .late(late), .timeout_err(timeout_err)
    );

    logic [41:0] obs;
    assign obs = {in_ready, fifo_count, red_in, red_start, pwm_level, pwm_load, underrun, late, timeout_err};

    function automatic logic [15:0] red_fn(input logic [15:0] x);
        return {x[7:0], x[15:8]} ^ 16'hA5C3;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reducer model: answers red_delay cycles after red_start (0 = random 1..12).
    int r_cnt = 0;
    logic [15:0] r_pend = 16'h0;
    initial begin
        red_rdy = 1'b0;
        red_out = 16'h0;
        forever begin
            @(negedge clk);
            red_rdy = 1'b0;
            if (r_cnt > 0) begin
                r_cnt--;
                if (r_cnt == 0) begin
                    red_rdy = 1'b1;
                    red_out = red_fn(r_pend);
                end
            end
            if (red_start === 1'b1) begin
                r_pend = red_in;
                r_cnt  = stall ? 0 : ((red_delay > 0) ? red_delay : int'($urandom_range(1, 12)));
            end
        end
    end

    // Reference model: mk is the cycle index since reset; e_vec predicts the outputs of cycle mk.
    int          mk = 0;
    bit          m_txn = 1'b0;
    int          m_idle_from = 0;
    int          m_wait_lo = 0;
    int          m_wait_hi = 0;
    logic [15:0] m_val;
    logic [15:0] mq [$];
    logic [15:0] e_red_in = 16'h0;
    logic [15:0] e_level = 16'h0;
    logic        e_start, e_load, e_under, e_late, e_to;
    logic [41:0] e_vec = RESET_VEC;
    initial begin
        bit tk, idl, do_push;
        forever begin
            @(posedge clk);
            e_start = 1'b0; e_load = 1'b0; e_under = 1'b0; e_late = 1'b0; e_to = 1'b0;
            if (rst) begin
                mq.delete();
                m_txn = 1'b0; m_idle_from = 0; mk = 0;
                e_red_in = 16'h0; e_level = 16'h0;
            end else begin
                tk      = (mk % 16) == 15;
                idl     = !m_txn && (mk >= m_idle_from);
                do_push = in_valid && (mq.size() < 8);
                e_late  = tk && !idl;
                e_under = tk && idl && (mq.size() == 0);
                if (m_txn && red_rdy === 1'b1 && mk >= m_wait_lo) begin
                    e_load = 1'b1; e_level = red_fn(m_val);
                    m_txn = 1'b0; m_idle_from = mk + 2;
                end else if (m_txn && mk == m_wait_hi) begin
                    e_to = 1'b1; m_txn = 1'b0; m_idle_from = mk + 1;
                end
                if (tk && idl && mq.size() != 0) begin
                    m_val = mq.pop_front();
                    e_red_in = m_val; e_start = 1'b1;
                    m_txn = 1'b1; m_wait_lo = mk + 2; m_wait_hi = mk + 16;
                end
                if (do_push) mq.push_back(in_data);
                mk++;
            end
            e_vec = {(mq.size() < 8), 4'(mq.size()), e_red_in, e_start, e_level, e_load, e_under, e_late, e_to};
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (obs !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_values: got %h expected %h", obs, RESET_VEC);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        red_delay = 2; stall = 1'b0;
        in_valid = 1'b1; in_data = 16'h1234;
        repeat (21) begin
            @(negedge clk);
            in_valid = 1'b0;
            n_chk++;
            if (obs !== e_vec) begin
                n_fail++; $display("FAIL basic_vec cycle %0d: got %h expected %h", mk, obs, e_vec);
            end
            if (mk == 16) begin
                n_chk++;
                if (red_start !== 1'b1 || red_in !== 16'h1234) begin
                    n_fail++; $display("FAIL basic_start: got start=%b red_in=%h expected 1/1234", red_start, red_in);
                end
            end
            if (mk == 19) begin
                n_chk++;
                if (pwm_load !== 1'b1 || pwm_level !== 16'h91D1) begin
                    n_fail++; $display("FAIL basic_load: got load=%b level=%h expected 1/91d1", pwm_load, pwm_level);
                end
            end
        end
    endtask

    task automatic test_negative;
        int n_load = 0;
        in_valid = 1'b1; in_data = 16'h8001;
        repeat (25) begin
            @(negedge clk);
            in_valid = 1'b0;
            n_chk++;
            if (obs !== e_vec) begin
                n_fail++; $display("FAIL negative_vec cycle %0d: got %h expected %h", mk, obs, e_vec);
            end
            if (red_start === 1'b1) begin
                n_chk++;
                if (red_in !== 16'h8001) begin
                    n_fail++; $display("FAIL negative_red_in: got %h expected 8001", red_in);
                end
            end
            if (pwm_load === 1'b1) n_load++;
        end
        n_chk++;
        if (n_load != 1 || pwm_level !== 16'hA443) begin
            n_fail++; $display("FAIL negative_result: got loads=%0d level=%h expected 1/a443", n_load, pwm_level);
        end
    endtask

    task automatic test_fill_wrap;
        logic [15:0] pushed [9];
        int c, idx, n_under;
        idx = 0; n_under = 0; red_delay = 0;
        for (int i = 0; i < 32 && (mk % 16) != 0; i++) @(negedge clk);
        c = mk;
        for (int i = 0; i < 9; i++) begin
            pushed[i] = 16'($urandom);
            in_valid = 1'b1; in_data = pushed[i];
            @(negedge clk);
            n_chk++;
            if (obs !== e_vec) begin
                n_fail++; $display("FAIL fill_vec cycle %0d: got %h expected %h", mk, obs, e_vec);
            end
            if (mk == c + 8) begin
                n_chk++;
                if (in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL fill_ready: got in_ready=%b expected 0", in_ready);
                end
            end
        end
        in_valid = 1'b0;
        n_chk++;
        if (fifo_count !== 4'd8 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL fill_full: got count=%0d ready=%b expected 8/0", fifo_count, in_ready);
        end
        repeat (137) begin
            @(negedge clk);
            n_chk++;
            if (obs !== e_vec) begin
                n_fail++; $display("FAIL drain_vec cycle %0d: got %h expected %h", mk, obs, e_vec);
            end
            if (pwm_load === 1'b1) begin
                n_chk++;
                if (idx > 7 || pwm_level !== red_fn(pushed[idx])) begin
                    n_fail++; $display("FAIL drain_order idx %0d: got %h expected %h", idx, pwm_level, red_fn(pushed[idx % 8]));
                end
                idx++;
            end
            if (underrun === 1'b1) n_under++;
        end
        n_chk++;
        if (idx != 8 || n_under != 1 || fifo_count !== 4'd0 || pwm_level !== red_fn(pushed[7])) begin
            n_fail++; $display("FAIL drain_end: got loads=%0d underruns=%0d count=%0d level=%h expected 8/1/0/%h",
                               idx, n_under, fifo_count, pwm_level, red_fn(pushed[7]));
        end
    endtask

    task automatic test_simul_full;
        int c;
        red_delay = 0;
        for (int i = 0; i < 32 && (mk % 16) != 0; i++) @(negedge clk);
        c = mk;
        repeat (165) begin
            in_valid = (mk - c < 16) || (mk - c == 63);
            in_data  = 16'($urandom);
            @(negedge clk);
            n_chk++;
            if (obs !== e_vec) begin
                n_fail++; $display("FAIL simul_vec cycle %0d: got %h expected %h", mk, obs, e_vec);
            end
            if (mk == c + 15) begin
                n_chk++;
                if (in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL simul_ready: got %b expected 0", in_ready);
                end
            end
            if (mk == c + 16 || mk == c + 64) begin
                n_chk++;
                if (fifo_count !== ((mk == c + 16) ? 4'd7 : 4'd5)) begin
                    n_fail++; $display("FAIL simul_count cycle %0d: got %0d expected %0d", mk - c, fifo_count, (mk == c + 16) ? 7 : 5);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall;
        int c;
        logic [15:0] s1, s2, lvl0;
        s1 = 16'($urandom); s2 = 16'($urandom);
        for (int i = 0; i < 32 && (mk % 16) != 0; i++) @(negedge clk);
        c = mk; stall = 1'b1; lvl0 = e_level;
        repeat (54) begin
            in_valid = (mk == c) || (mk == c + 20);
            in_data  = (mk == c) ? s1 : s2;
            if (mk == c + 20) begin
                stall = 1'b0; red_delay = 2;
            end
            @(negedge clk);
            n_chk++;
            if (obs !== e_vec) begin
                n_fail++; $display("FAIL stall_vec cycle %0d: got %h expected %h", mk, obs, e_vec);
            end
            if (mk == c + 32) begin
                n_chk++;
                if (timeout_err !== 1'b1 || late !== 1'b1 || pwm_level !== lvl0) begin
                    n_fail++; $display("FAIL stall_timeout: got to=%b late=%b level=%h expected 1/1/%h", timeout_err, late, pwm_level, lvl0);
                end
            end
            if (mk == c + 51) begin
                n_chk++;
                if (pwm_load !== 1'b1 || pwm_level !== red_fn(s2)) begin
                    n_fail++; $display("FAIL stall_recover: got load=%b level=%h expected 1/%h", pwm_load, pwm_level, red_fn(s2));
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_late_reset;
        int n_load = 0;
        for (int i = 0; i < 32 && (mk % 16) != 0; i++) @(negedge clk);
        stall = 1'b1;
        for (int j = 0; j < 45; j++) begin
            in_valid = (j < 2);
            in_data  = 16'($urandom);
            rst      = (j == 20);
            @(negedge clk);
            n_chk++;
            if (j == 20) begin
                if (obs !== RESET_VEC) begin
                    n_fail++; $display("FAIL midreset_values: got %h expected %h", obs, RESET_VEC);
                end
            end else if (obs !== e_vec) begin
                n_fail++; $display("FAIL midreset_vec step %0d: got %h expected %h", j, obs, e_vec);
            end
            if (pwm_load === 1'b1) n_load++;
        end
        rst = 1'b0; in_valid = 1'b0;
        n_chk++;
        if (n_load != 0) begin
            n_fail++; $display("FAIL midreset_load: got %0d pwm_load pulses expected 0", n_load);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 16'h0;
        test_reset;
        test_basic;
        test_negative;
        test_fill_wrap;
        test_simul_full;
        test_stall;
        test_late_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
